// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the 64-bit ALU: RAW scoreboard with writeback bypass, one registered issue slot.
// Latency 1 cycle accept->out_valid; stalls fetch when the slot is held or a source register is busy.
module alu_issue_stage #(
   parameter int XLEN  = 64,
   parameter int IMM_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic [4:0]      rf_raddr1,
   output logic [4:0]      rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_sel,
   output logic [XLEN-1:0] out_src1,
   output logic [XLEN-1:0] out_src2,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   typedef struct packed {
      logic [3:0]      alu_sel;
      logic [XLEN-1:0] src1;
      logic [XLEN-1:0] src2;
      logic [4:0]      rd;
      logic            illegal;
   } issue_t;

   logic [5:0]       opcode;
   logic [4:0]       rd, rs1, rs2;
   logic [IMM_W-1:0] imm;
   logic [XLEN-1:0]  rs1_val, rs2_val, imm_ext;
   logic             is_reg, is_imm, is_mov, zext;
   logic             use_rs1, use_rs2;
   logic             byp1, byp2, blk1, blk2;
   logic             hazard, accept;
   logic [31:0]      busy;
   logic             valid_q;
   issue_t           slot_q, slot_d;

   assign opcode    = in_instr[31:26];
   assign rd        = in_instr[25:21];
   assign rs1       = in_instr[20:16];
   assign rs2       = in_instr[15:11];
   assign imm       = in_instr[IMM_W-1:0];
   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;

   assign is_reg  = (opcode <= 6'h06);
   assign is_imm  = (opcode >= 6'h08) && (opcode <= 6'h0E);
   assign is_mov  = (opcode == 6'h0F);
   assign zext    = (opcode >= 6'h0A) && (opcode <= 6'h0C);
   assign use_rs1 = is_reg || is_imm || is_mov;
   assign use_rs2 = is_reg;

   assign imm_ext = zext ? {{(XLEN-IMM_W){1'b0}}, imm}
                         : {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

   // r0 never bypasses and always reads as zero, whatever the register file returns
   assign byp1    = wb_valid && (wb_rd == rs1) && (rs1 != 5'd0);
   assign byp2    = wb_valid && (wb_rd == rs2) && (rs2 != 5'd0);
   assign rs1_val = (rs1 == 5'd0) ? '0 : (byp1 ? wb_data : rf_rdata1);
   assign rs2_val = (rs2 == 5'd0) ? '0 : (byp2 ? wb_data : rf_rdata2);

   assign blk1 = busy[rs1] && !(wb_valid && (wb_rd == rs1));
   assign blk2 = busy[rs2] && !(wb_valid && (wb_rd == rs2));

   assign hazard   = in_valid && ((use_rs1 && blk1) || (use_rs2 && blk2));
   assign in_ready = (!valid_q || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   always_comb begin
      slot_d         = '0;
      slot_d.alu_sel = 4'hF;
      slot_d.rd      = rd;
      slot_d.illegal = 1'b1;
      if (is_reg) begin
         slot_d.alu_sel = opcode[3:0];
         slot_d.src1    = rs1_val;
         slot_d.src2    = rs2_val;
         slot_d.illegal = 1'b0;
      end else if (is_imm) begin
         slot_d.alu_sel = {1'b0, opcode[2:0]};
         slot_d.src1    = rs1_val;
         slot_d.src2    = imm_ext;
         slot_d.illegal = 1'b0;
      end else if (is_mov) begin
         slot_d.src1    = rs1_val;
         slot_d.illegal = 1'b0;
      end
   end

   // set takes priority over a same-cycle writeback clear; bit 0 stays cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (accept && use_rs1 && (rd == 5'(i)))
               busy[i] <= 1'b1;
            else if (wb_valid && (wb_rd == 5'(i)))
               busy[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         slot_q  <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         slot_q  <= slot_d;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid   = valid_q;
   assign out_alu_sel = slot_q.alu_sel;
   assign out_src1    = slot_q.src1;
   assign out_src2    = slot_q.src2;
   assign out_rd      = slot_q.rd;
   assign out_illegal = slot_q.illegal;

endmodule
